dsp_chain_drain: RTL and testbench
==================================

Name: dsp_chain_drain

Overview:
Tail-end consumer of an int_sop_2 DSP cascade. It takes the 37-bit chainout of the last chain stage and accumulates it over multiple passes for dot products longer than the chain. It then rounds, shifts and saturates the result to OUT_W and emits it through a small output FIFO with a valid/ready handshake.
The chain cannot stall, so the drain never backpressures its input. Instead it raises an advisory hold to the chain feeder.

Parameters:
CHAIN_W, 37, chain word width (signed two's complement)
ACC_W, 48, accumulator width (signed)
OUT_W, 16, output result width (signed)
SHIFT_W, 6, width of the cfg_shift field
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock; all logic is rising-edge
reset  in  1  synchronous, active-low reset (0 = reset asserted)
chain_in  in  CHAIN_W  chainout of last DSP stage, signed
in_valid  in  1  chain_in carries a valid partial sum this cycle
in_first  in  1  beat is first pass of a dot product
in_last  in  1  beat is last pass of a dot product
cfg_shift  in  SHIFT_W  right-shift amount; sampled on the in_last beat
clr_flags  in  1  clears the sticky error flags
out_data  out  OUT_W  result at FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts the head when out_valid && out_ready
in_hold  out  1  advisory to the feeder: stop issuing new dot products
sat_flag  out  1  sticky: a result saturated
drop_err  out  1  sticky: a result was dropped because the FIFO was full
proto_err  out  1  sticky: first/last sequencing violation

Behaviour:
- Reset (reset==0 at a clock edge):
  - acc=0, FSM=IDLE, pipeline valids=0, FIFO emptied.
  - out_data=0, out_valid=0, in_hold=0, all sticky flags=0.
  - Reset mid-accumulation discards the partial sum. Reset dominates clr_flags.
- Stage A (accumulate), FSM states IDLE and ACCUM:
  - IDLE, in_valid&&in_first: acc<=sext(chain_in); go to ACCUM, or stay IDLE if in_last is also set (single-pass result).
  - IDLE, in_valid&&!in_first: treated as first; proto_err<=1.
  - ACCUM, in_valid&&!in_first: acc<=acc+sext(chain_in). If in_last, go to IDLE.
  - ACCUM, in_valid&&in_first: partial is discarded, acc<=sext(chain_in), proto_err<=1.
  - in_valid==0: acc and state hold; in_first/in_last are ignored.
  - The accumulator wraps modulo 2^ACC_W; there is no overflow detection in acc.
- Stage B (round), fires the cycle after an in_last beat:
  - s = cfg_shift latched on the in_last beat.
  - r = (acc + (s>0 ? 2^(s-1) : 0)) >>> s. Arithmetic shift, round-half-up; the addition is done at ACC_W+1 bits.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. If clamping occurs, set sat_flag.
- Stage C (push): the registered result is written to the FIFO.
- Latency: in_last beat sampled at edge T; the result is at the FIFO head with out_valid=1 after edge T+3, provided the FIFO was empty.
- Throughput: one result per cycle (back-to-back single-pass beats allowed).
- FIFO:
  - Pop when out_valid&&out_ready.
  - Push while full and no pop in the same cycle: the result is dropped, drop_err<=1, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur; nothing is dropped.
  - Ordering is strict FIFO.
  - out_data is held stable while out_valid&&!out_ready.
- in_hold = (fifo_count + results in stages B/C) >= FIFO_DEPTH-1. It is combinational from registers only.
- clr_flags=1 clears all sticky flags at the edge. A flag event in the same cycle wins, so that flag stays 1.

Optional Feature:
DSP_DRAIN_RELU_EN:
- Defined: stage B forces r to 0 when r<0, before saturation. A ReLU clamp does not set sat_flag.
- Undefined: signed results pass unchanged; no extra logic.

Decomposition:
- Shared package dsp_chain_pkg holds:
  - constants CHAIN_W_DEF=37, ACC_W_DEF=48, OUT_W_DEF=16
  - enum drain_state_t {IDLE, ACCUM}
  - function sat_round(acc, shift) returning {sat, value}
- One sub-module: drain_fifo (sync FIFO with count, full/empty, drop-on-full push). It uses the same clk and active-low sync reset.

Test Plan:
- Passes 100, 200, 300 (first..last), shift=2, out_ready=1 -> out_data=150 at T+3; sat_flag=0, proto_err=0.
- Single beat (first&last) chain_in=40000, shift=0 -> out_data=32767, sat_flag=1. Beat -40000 -> out_data=-32768.
- Single beat -5, shift=1 -> out_data=-2. With DSP_DRAIN_RELU_EN defined -> out_data=0 and sat_flag=0.
- out_ready=0, five single-beat results 1..5, FIFO_DEPTH=4:
  - in_hold=1 once three results are in flight or queued
  - 5th result dropped, drop_err=1
  - after releasing out_ready, outputs are 1,2,3,4 in order
- Beat 7 (first, not last), then beat 9 (first) mid-accumulation, then beat 1 (last) -> proto_err=1, out_data=10. Then clr_flags=1 -> proto_err=0.
- Beat 50 (first), reset=0 for one cycle, then beat 3 (first&last) -> out_data=3; out_valid=0 while reset is asserted.

Source files
------------

// File: rtl/dsp_chain_pkg.sv
// Shared types, default widths and the round/shift/saturate helper for the
// DSP chain drain.
package dsp_chain_pkg;

    localparam int CHAIN_W_DEF = 37;
    localparam int ACC_W_DEF   = 48;
    localparam int OUT_W_DEF   = 16;
    localparam int SHIFT_W_DEF = 6;

    // The rounding arithmetic is carried out at this width. Operands are
    // sign-extended into it, so the carry of acc + bias can never be lost.
    localparam int SR_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } drain_state_t;

    typedef struct packed {
        logic            sat;
        logic [SR_W-1:0] value;
    } sat_res_t;

    // Round half-up, arithmetic right shift by 'shift', then clamp to a
    // signed out_w-bit range. The sat bit reports that clamping happened.
    function automatic sat_res_t sat_round(input logic signed [SR_W-1:0] acc,
                                           input logic [7:0]              shift,
                                           input int                      out_w);
        logic signed [SR_W-1:0] bias;
        logic signed [SR_W-1:0] sum;
        logic signed [SR_W-1:0] r;
        logic signed [SR_W-1:0] hi;
        logic signed [SR_W-1:0] lo;
        sat_res_t               res;
        bias = (shift != 8'd0) ? (64'sd1 <<< (shift - 8'd1)) : 64'sd0;
        sum  = acc + bias;
        r    = sum >>> shift;
        hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (out_w - 1));
        res.sat   = 1'b0;
        res.value = r;
        if (r > hi) begin
            res.sat   = 1'b1;
            res.value = hi;
        end else if (r < lo) begin
            res.sat   = 1'b1;
            res.value = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/dsp_chain_drain_fifo.sv
// drain_fifo: small synchronous FIFO with occupancy count. A push while full
// without a simultaneous pop is discarded and reported on drop_o.
module drain_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and count; reset clears storage so the head reads 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dsp_chain_drain.sv
// dsp_chain_drain: accumulates multi-pass chainout words, rounds/shifts/
// saturates the dot product and queues it in an output FIFO.
// Optional build macro DSP_DRAIN_RELU_EN: negative results become 0 before
// saturation (not reported as saturation).
module dsp_chain_drain
    import dsp_chain_pkg::*;
#(
    parameter int CHAIN_W    = CHAIN_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int SHIFT_W    = SHIFT_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CHAIN_W-1:0] chain_in,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               clr_flags,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               in_hold,
    output logic               sat_flag,
    output logic               drop_err,
    output logic               proto_err
);

    // vld_pipe_q[0]: acc holds a finished sum (stage B input)
    // vld_pipe_q[1]: stage B result register valid
    // vld_pipe_q[2]: stage C push register valid
    localparam int STAGES = 2;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int HOLD_W = CNT_W + 1;

    drain_state_t        state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [SHIFT_W-1:0]  shift_q;
    logic [STAGES:0]     vld_pipe_q;
    logic [OUT_W-1:0]    b_data_q, c_data_q;
    logic                sat_q, drop_q, proto_q;

    logic [ACC_W-1:0]    chain_sx;
    logic                proto_evt;
    logic                sat_evt;
    logic                last_beat;
    sat_res_t            res_b;

    logic [CNT_W-1:0]    fifo_cnt;
    logic                fifo_full, fifo_empty, fifo_drop;
    logic [HOLD_W-1:0]   hold_cnt;

    assign chain_sx  = {{(ACC_W-CHAIN_W){chain_in[CHAIN_W-1]}}, chain_in};
    assign last_beat = in_valid && in_last;

    // Stage A: accumulate FSM next state; a stray first discards the partial.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        proto_evt = 1'b0;
        if (in_valid) begin
            if (state_q == IDLE || in_first) begin
                acc_d     = chain_sx;
                proto_evt = (state_q == IDLE) ? !in_first : in_first;
            end else begin
                acc_d = acc_q + chain_sx;
            end
            state_d = in_last ? IDLE : ACCUM;
        end
    end

    // Stage A registers: FSM state, accumulator and the shift for this result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (last_beat) shift_q <= cfg_shift;
        end
    end

    // Stage B: round, shift, optional ReLU, saturate from the finished acc.
    always_comb begin
        res_b = sat_round({{(SR_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}, 8'(shift_q), OUT_W);
`ifdef DSP_DRAIN_RELU_EN
        if (res_b.value[SR_W-1]) begin
            res_b.sat   = 1'b0;
            res_b.value = '0;
        end
`endif
    end

    assign sat_evt = vld_pipe_q[0] && res_b.sat;

    // Result pipeline B -> C with its valid shift register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_pipe_q <= '0;
            b_data_q   <= '0;
            c_data_q   <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], last_beat};
            if (vld_pipe_q[0]) b_data_q <= res_b.value[OUT_W-1:0];
            if (vld_pipe_q[1]) c_data_q <= b_data_q;
        end
    end

    // Stage C pushes into the output queue; the chain is never stalled.
    drain_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (vld_pipe_q[2]),
        .push_data_i (c_data_q),
        .pop_i       (out_ready),
        .pop_data_o  (out_data),
        .count_o     (fifo_cnt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .drop_o      (fifo_drop)
    );

    assign out_valid = !fifo_empty;

    // Sticky flags: a same-cycle event beats clr_flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            sat_q   <= (sat_q   && !clr_flags) || sat_evt;
            drop_q  <= (drop_q  && !clr_flags) || fifo_drop;
            proto_q <= (proto_q && !clr_flags) || proto_evt;
        end
    end

    assign sat_flag  = sat_q;
    assign drop_err  = drop_q;
    assign proto_err = proto_q;

    // Hold counts queued results plus everything still in the pipeline.
    assign hold_cnt = HOLD_W'(fifo_cnt) + HOLD_W'(vld_pipe_q[0])
                    + HOLD_W'(vld_pipe_q[1]) + HOLD_W'(vld_pipe_q[2]);
    assign in_hold  = (hold_cnt >= HOLD_W'(FIFO_DEPTH - 1));

    // fifo_full is only used inside the FIFO's own drop logic.
    logic unused_ok;
    assign unused_ok = fifo_full;

endmodule

// File: tb/tb_dsp_chain_drain.sv
// Directed bench for dsp_chain_drain; expected values are hand-computed.
// Honours DSP_DRAIN_RELU_EN when choosing expected values for negatives.
module tb_dsp_chain_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic [36:0] chain_in;
    logic        in_valid, in_first, in_last;
    logic [5:0]  cfg_shift;
    logic        clr_flags;
    logic [15:0] out_data;
    logic        out_valid, out_ready;
    logic        in_hold, sat_flag, drop_err, proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dsp_chain_drain dut (
        .clk       (clk),
        .reset     (reset),
        .chain_in  (chain_in),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .cfg_shift (cfg_shift),
        .clr_flags (clr_flags),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_hold   (in_hold),
        .sat_flag  (sat_flag),
        .drop_err  (drop_err),
        .proto_err (proto_err)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One beat sampled at the next rising edge; inputs drop 1ns later.
    task automatic beat(input longint d, input logic f, input logic l, input int s);
        chain_in  = 37'(d);
        in_first  = f;
        in_last   = l;
        cfg_shift = 6'(s);
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic clr();
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
    endtask

    // Single-pass result, checked at the FIFO head after edge T+3, then popped.
    task automatic single(input string tag, input longint d, input int s, input longint exp);
        beat(d, 1'b1, 1'b1, s);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_vld"}, longint'(out_valid), 1);
        chk({tag, "_data"}, longint'($signed(out_data)), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; chain_in = '0; in_valid = 1'b0; in_first = 1'b0;
        in_last = 1'b0; cfg_shift = '0; clr_flags = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",   longint'(out_valid), 0);
        chk("rst_data",  longint'(out_data),  0);
        chk("rst_hold",  longint'(in_hold),   0);
        chk("rst_sat",   longint'(sat_flag),  0);
        chk("rst_drop",  longint'(drop_err),  0);
        chk("rst_proto", longint'(proto_err), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Three passes: (600 + 2) >>> 2 = 150, visible exactly after T+3.
        beat(100, 1'b1, 1'b0, 2);
        beat(200, 1'b0, 1'b0, 2);
        beat(300, 1'b0, 1'b1, 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lat_t2_vld", longint'(out_valid), 0);
        @(posedge clk); @(negedge clk);
        chk("lat_t3_vld", longint'(out_valid), 1);
        chk("dot3_data",  longint'($signed(out_data)), 150);
        chk("dot3_sat",   longint'(sat_flag),  0);
        chk("dot3_proto", longint'(proto_err), 0);
        @(posedge clk); @(negedge clk);
        chk("dot3_popped", longint'(out_valid), 0);

        // Saturation at both rails.
        single("satp", 40000, 0, 32767);
        chk("satp_flag", longint'(sat_flag), 1);
        clr();
        chk("sat_clr", longint'(sat_flag), 0);
        single("satn", -40000, 0, -32768);
        chk("satn_flag", longint'(sat_flag), 1);
        clr();

        // Negative rounding: -5>>>1 rounds to -2, -6>>>2 rounds half-up to -1.
`ifdef DSP_DRAIN_RELU_EN
        single("neg5", -5, 1, 0);
        chk("neg5_sat", longint'(sat_flag), 0);
        single("neg6", -6, 2, 0);
`else
        single("neg5", -5, 1, -2);
        chk("neg5_sat", longint'(sat_flag), 0);
        single("neg6", -6, 2, -1);
`endif
        single("pos6", 6, 2, 2);

        // Backpressure: five back-to-back results into a 4-deep FIFO.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chain_in = 37'(k); in_first = 1'b1; in_last = 1'b1;
            cfg_shift = '0; in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            chk($sformatf("hold_b%0d", k), longint'(in_hold), (k >= 3) ? 1 : 0);
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("full_drop0", longint'(drop_err), 0);
        chk("full_hold",  longint'(in_hold),  1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("full_drop1", longint'(drop_err), 1);
        chk("stall_data", longint'($signed(out_data)), 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain%0d_vld", k), longint'(out_valid), 1);
            chk($sformatf("drain%0d_data", k), longint'($signed(out_data)), k);
            @(posedge clk); @(negedge clk);
        end
        chk("drain_empty", longint'(out_valid), 0);
        chk("drain_hold",  longint'(in_hold),   0);

        // Protocol error: stray first mid-accumulation restarts the sum.
        clr();
        chk("clr_drop", longint'(drop_err), 0);
        beat(7, 1'b1, 1'b0, 0);
        @(negedge clk);
        chk("proto_ok", longint'(proto_err), 0);
        beat(9, 1'b1, 1'b0, 0);
        @(negedge clk);
        chk("proto_set", longint'(proto_err), 1);
        beat(1, 1'b0, 1'b1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("proto_vld",  longint'(out_valid), 1);
        chk("proto_data", longint'($signed(out_data)), 10);
        clr();
        @(negedge clk);
        chk("proto_clr", longint'(proto_err), 0);

        // Reset mid-accumulation discards the partial sum.
        beat(50, 1'b1, 1'b0, 0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_vld",  longint'(out_valid), 0);
        chk("mid_rst_data", longint'(out_data),  0);
        reset = 1'b1;
        beat(3, 1'b1, 1'b1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_vld",   longint'(out_valid), 1);
        chk("post_rst_data",  longint'($signed(out_data)), 3);
        chk("post_rst_proto", longint'(proto_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
